matrix_loader: RTL and testbench
================================

# matrix_loader

Byte-stream front end for the 16x16 matrix multiplier. Parses commands arriving from the UART receive path, writes 256-byte operand matrices into the A and B memories, and pulses the multiplier's `start` once both operands are present. While a multiplication runs, it holds off the byte stream until the multiplier's one-cycle `done` pulse returns. It owns the write side of the memories the multiplier reads.

## Interface
Parameters:
- `N_ELEM`, 256: bytes per matrix, row-major, address = row*16 + col.
- `CMD_LOAD_A`, 8'hA1: load matrix A.
- `CMD_LOAD_B`, 8'hB1: load matrix B.
- `CMD_START`, 8'h5A: launch multiplication.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous active-low reset.
- `rx_valid` in 1: byte available from UART RX.
- `rx_data` in 8: received byte.
- `rx_ready` out 1: loader accepts the byte this cycle.
- `a_we` out 1: A memory write enable.
- `a_waddr` out 8: A memory write address.
- `a_wdata` out 8: A memory write data.
- `b_we` out 1: B memory write enable.
- `b_waddr` out 8: B memory write address.
- `b_wdata` out 8: B memory write data.
- `mm_start` out 1: one-cycle start pulse to the multiplier.
- `mm_done` in 1: one-cycle done pulse from the multiplier.
- `a_loaded` out 1: A holds a complete, valid matrix.
- `b_loaded` out 1: B holds a complete, valid matrix.
- `busy` out 1: multiplication in flight.
- `err` out 1: one-cycle error pulse.
- `err_code` out 2: reason for the error. Held until the next `err`.
  - 1 = unknown command
  - 2 = checksum mismatch
  - 3 = start issued without both matrices loaded

## Operation
- Handshake: a byte is accepted when `rx_valid && rx_ready`. `rx_ready` is 1 in every state except `RUN`.
- States:
  - `IDLE`:
    - `CMD_LOAD_A` → `LOAD`, target A, clear `a_loaded`.
    - `CMD_LOAD_B` → `LOAD`, target B, clear `b_loaded`.
    - `CMD_START` with both loaded → pulse `mm_start`, go to `RUN`.
    - `CMD_START` with either flag clear → `err`, code 3, stay in `IDLE`.
    - Any other byte → `err`, code 1, stay in `IDLE`.
  - `LOAD`:
    - Each accepted byte n (0..255) is written to the target memory at address n.
    - An 8-bit counter increments per accepted byte.
    - After byte 255 (counter wraps to 0): go to `CHECK` if checksum is compiled in. Otherwise set the target's loaded flag and go to `IDLE`.
    - Command byte values carry no meaning inside `LOAD`; every byte is treated as data.
  - `CHECK`: see Configuration.
  - `RUN`: `busy` = 1, `rx_ready` = 0. `mm_done` → `IDLE`, `busy` = 0.
- Loaded flags persist across runs, so a new `CMD_START` reuses the same operands.
- A `mm_done` pulse outside `RUN` is ignored.
- Reset mid-`LOAD` or mid-`RUN` returns to `IDLE` and clears both loaded flags. The partial memory contents are left as-is; they become unusable because the flags are cleared.

## Timing
- Reset values: `rx_ready` = 1; all other outputs 0, including `err_code`.
- All outputs are registered.
- Memory write: `a_we`/`b_we` is high for exactly one cycle, the cycle after acceptance, with that cycle's address and data.
- `mm_start` fires the cycle after the `CMD_START` byte is accepted. `busy` rises in the same cycle.
- `busy` falls the cycle after `mm_done`. `rx_ready` rises in the same cycle.
- `err` fires the cycle after the offending byte is accepted.
- The loaded flag sets the cycle after the final byte is accepted (or after the checksum byte, when compiled in).
- Back-to-back bytes (`rx_valid` held high) are accepted every cycle in `IDLE`, `LOAD` and `CHECK`. No bubbles.

## Configuration
- `MATRIX_LOADER_CHECKSUM_EN` defined:
  - `LOAD` keeps a running 8-bit sum (mod 256) of the data bytes, cleared on entry to `LOAD`.
  - `CHECK` accepts one byte. If it equals the sum, set the loaded flag. Otherwise pulse `err` with code 2 and leave the flag clear.
  - Either way, return to `IDLE`.
- Macro undefined: no accumulator, no `CHECK` state. The stream is 1 command byte + 256 data bytes.

## Structure
- Shared package `matrix_pkg`:
  - state enum `loader_state_t` (`IDLE`, `LOAD`, `CHECK`, `RUN`)
  - command byte constants
  - `err_code` constants
  - `MATRIX_DIM` = 16
- One sub-module, `matrix_mem_wport`: a registered write-port driver (we/addr/data pipeline), instantiated once for A and once for B.

## Test plan
- A loaded with bytes 0..255 (checksum 8'h80 when enabled), then B likewise → A/B memories hold addr == data; `a_loaded` = `b_loaded` = 1; exactly 256 writes per memory.
- Both loaded, send 8'h5A → `mm_start` one cycle; `busy` = 1 and `rx_ready` = 0 until a stubbed `mm_done` after 100 cycles; a second 8'h5A afterwards pulses `mm_start` again.
- Send 8'h5A after loading only A → `err` pulse, `err_code` = 3, no `mm_start`.
- Send 8'h33 in `IDLE` → `err`, `err_code` = 1; a following `CMD_LOAD_A` proceeds normally.
- With the checksum macro, 256 bytes of 8'h01 then checksum 8'h01 → `err`, code 2, `b_loaded` stays 0. Repeat with checksum 8'h00 → `b_loaded` = 1.
- Assert `rst_n` low for one cycle after 100 bytes of an A load → flags 0, `IDLE`; a full reload then completes correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared states, command bytes and error codes for the matrix loader.
package matrix_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} loader_state_t;
    localparam logic [7:0] CMD_LOAD_A_DFLT = 8'hA1;
    localparam logic [7:0] CMD_LOAD_B_DFLT = 8'hB1;
    localparam logic [7:0] CMD_START_DFLT  = 8'h5A;
    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_UNKNOWN_CMD = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM    = 2'd2;
    localparam logic [1:0] ERR_NOT_LOADED  = 2'd3;
    localparam int MATRIX_DIM = 16;
endpackage

// File: rtl/matrix_mem_wport.sv
// matrix_mem_wport: registered write-port driver (we/addr/data one cycle after the request).
module matrix_mem_wport (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       we,
    output logic [7:0] waddr,
    output logic [7:0] wdata
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= en;
            if (en) begin
                waddr <= addr;
                wdata <= data;
            end
        end
    end
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: UART byte-stream parser loading A/B operand memories and launching the multiplier.
// Define MATRIX_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte after each matrix.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int         N_ELEM     = MATRIX_DIM * MATRIX_DIM,
    parameter logic [7:0] CMD_LOAD_A = CMD_LOAD_A_DFLT,
    parameter logic [7:0] CMD_LOAD_B = CMD_LOAD_B_DFLT,
    parameter logic [7:0] CMD_START  = CMD_START_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       a_we,
    output logic [7:0] a_waddr,
    output logic [7:0] a_wdata,
    output logic       b_we,
    output logic [7:0] b_waddr,
    output logic [7:0] b_wdata,
    output logic       mm_start,
    input  logic       mm_done,
    output logic       a_loaded,
    output logic       b_loaded,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);
    loader_state_t state;
    logic [7:0] cnt;
    logic tgt;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif
    logic accept;
    assign accept = rx_valid && rx_ready;

    matrix_mem_wport u_a (
        .clk(clk), .rst_n(rst_n), .en(accept && state == LOAD && !tgt),
        .addr(cnt), .data(rx_data), .we(a_we), .waddr(a_waddr), .wdata(a_wdata)
    );
    matrix_mem_wport u_b (
        .clk(clk), .rst_n(rst_n), .en(accept && state == LOAD && tgt),
        .addr(cnt), .data(rx_data), .we(b_we), .waddr(b_waddr), .wdata(b_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            tgt      <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
            rx_ready <= 1'b1;
            mm_start <= 1'b0;
            a_loaded <= 1'b0;
            b_loaded <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            mm_start <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    sum <= '0;
`endif
                    if (rx_data == CMD_LOAD_A) begin
                        state    <= LOAD;
                        tgt      <= 1'b0;
                        a_loaded <= 1'b0;
                    end else if (rx_data == CMD_LOAD_B) begin
                        state    <= LOAD;
                        tgt      <= 1'b1;
                        b_loaded <= 1'b0;
                    end else if (rx_data == CMD_START) begin
                        if (a_loaded && b_loaded) begin
                            state    <= RUN;
                            mm_start <= 1'b1;
                            busy     <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_NOT_LOADED;
                        end
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_UNKNOWN_CMD;
                    end
                end
                LOAD: if (accept) begin
                    cnt <= cnt + 8'd1;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    sum <= sum + rx_data;
                    if (cnt == 8'(N_ELEM - 1)) state <= CHECK;
`else
                    if (cnt == 8'(N_ELEM - 1)) begin
                        state <= IDLE;
                        if (tgt) b_loaded <= 1'b1;
                        else a_loaded <= 1'b1;
                    end
`endif
                end
`ifdef MATRIX_LOADER_CHECKSUM_EN
                CHECK: if (accept) begin
                    state <= IDLE;
                    if (rx_data == sum) begin
                        if (tgt) b_loaded <= 1'b1;
                        else a_loaded <= 1'b1;
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_CHECKSUM;
                    end
                end
`endif
                RUN: if (mm_done) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rx_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: scoreboard bench; stimulus queues expected write/start/err events, a monitor pops them.
// Define MATRIX_LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum path.
module tb_matrix_loader;
    logic clk = 1'b0;
    logic rst_n, rx_valid, rx_ready, mm_done, mm_start;
    logic [7:0] rx_data;
    logic a_we, b_we, a_loaded, b_loaded, busy, err;
    logic [7:0] a_waddr, a_wdata, b_waddr, b_wdata;
    logic [1:0] err_code;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [7:0] data;
    } evt_t;

    localparam logic [1:0] K_A = 2'd0, K_B = 2'd1, K_START = 2'd2, K_ERR = 2'd3;

    evt_t q[$];
    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .mm_start(mm_start), .mm_done(mm_done), .a_loaded(a_loaded), .b_loaded(b_loaded),
        .busy(busy), .err(err), .err_code(err_code)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        vec++;
        if (act !== req) begin
            mis++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
        evt_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
        evt_t e;
        vec++;
        if (q.size() == 0) begin
            mis++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none", k, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind !== k || e.addr !== a || e.data !== d) begin
                mis++;
                $display("FAIL event: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (a_we === 1'b1) pop_cmp(K_A, a_waddr, a_wdata);
        if (b_we === 1'b1) pop_cmp(K_B, b_waddr, b_wdata);
        if (mm_start === 1'b1) pop_cmp(K_START, 8'h00, 8'h00);
        if (err === 1'b1) pop_cmp(K_ERR, 8'h00, {6'd0, err_code});
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Command byte plus 256 data bytes; data is fill value or index^xr.
    task automatic load(input bit b, input logic [7:0] xr, input bit fill, input logic [7:0] cks_delta);
        logic [7:0] d;
        logic [7:0] s;
        s = 8'h00;
        send(b ? 8'hB1 : 8'hA1);
        for (int i = 0; i < 256; i++) begin
            d = fill ? xr : (8'(i) ^ xr);
            s = s + d;
            expect_evt(b ? K_B : K_A, 8'(i), d);
            send(d);
        end
`ifdef MATRIX_LOADER_CHECKSUM_EN
        if (cks_delta != 8'h00) expect_evt(K_ERR, 8'h00, 8'h02);
        send(s + cks_delta);
`else
        if (s == cks_delta) idle(0);
`endif
    endtask

    task automatic run_once(input int cycles);
        bit ok;
        expect_evt(K_START, 8'h00, 8'h00);
        send(8'h5A);
        chk("busy_rise", {15'd0, busy}, 16'd1);
        chk("rx_ready_low", {15'd0, rx_ready}, 16'd0);
        rx_valid = 1'b1;
        rx_data = 8'h33;
        ok = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || rx_ready !== 1'b0) ok = 1'b0;
        end
        chk("run_hold", {15'd0, ok}, 16'd1);
        rx_valid = 1'b0;
        mm_done = 1'b1;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
        chk("busy_fall", {15'd0, busy}, 16'd0);
        chk("rx_ready_rise", {15'd0, rx_ready}, 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        mm_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_ready", {15'd0, rx_ready}, 16'd1);
        chk("reset_outs", {a_we, b_we, mm_start, a_loaded, b_loaded, busy, err, err_code},
            16'd0);
        chk("reset_addr", {a_waddr, b_waddr}, 16'h0000);
        rst_n = 1'b1;
        idle(1);

        load(1'b0, 8'h00, 1'b0, 8'h00);
        idle(2);
        chk("a_loaded_after_a", {15'd0, a_loaded}, 16'd1);
        chk("b_loaded_after_a", {15'd0, b_loaded}, 16'd0);

        expect_evt(K_ERR, 8'h00, 8'h03);
        send(8'h5A);
        idle(3);
        chk("err_code_held_3", {14'd0, err_code}, 16'd3);
        chk("no_busy_on_err", {15'd0, busy}, 16'd0);

        expect_evt(K_ERR, 8'h00, 8'h01);
        send(8'h33);
        load(1'b1, 8'h00, 1'b0, 8'h00);
        idle(2);
        chk("err_code_held_1", {14'd0, err_code}, 16'd1);
        chk("both_loaded", {14'd0, a_loaded, b_loaded}, 16'd3);

        run_once(100);
        idle(2);
        run_once(5);
        chk("flags_persist", {14'd0, a_loaded, b_loaded}, 16'd3);

        mm_done = 1'b1;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
        idle(2);
        chk("stray_done_busy", {15'd0, busy}, 16'd0);

`ifdef MATRIX_LOADER_CHECKSUM_EN
        load(1'b1, 8'h01, 1'b1, 8'h01);
        idle(2);
        chk("cks_bad_b_loaded", {15'd0, b_loaded}, 16'd0);
        chk("cks_bad_code", {14'd0, err_code}, 16'd2);
        load(1'b1, 8'h01, 1'b1, 8'h00);
        idle(2);
        chk("cks_good_b_loaded", {15'd0, b_loaded}, 16'd1);
`endif

        send(8'hA1);
        for (int i = 0; i < 100; i++) begin
            expect_evt(K_A, 8'(i), 8'(i) ^ 8'hC3);
            send(8'(i) ^ 8'hC3);
        end
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midreset_flags", {14'd0, a_loaded, b_loaded}, 16'd0);
        chk("midreset_state", {13'd0, busy, rx_ready, err}, 16'd2);
        chk("midreset_err_code", {14'd0, err_code}, 16'd0);

        load(1'b0, 8'h5A, 1'b0, 8'h00);
        idle(2);
        chk("reload_flags", {14'd0, a_loaded, b_loaded}, 16'd2);
        expect_evt(K_ERR, 8'h00, 8'h03);
        send(8'h5A);
        idle(5);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
